// File: rtl/lcd_pkg.sv
// rtl/lcd_pkg.sv - shared types and constants for the HD44780 character-LCD driver
package lcd_pkg;

   // Controller sequencing states
   typedef enum logic [2:0] {
      ST_PWRUP,
      ST_INIT,
      ST_SETUP,
      ST_PULSE,
      ST_HOLD,
      ST_WAIT,
      ST_IDLE
   } lcd_state_e;

   // Power-up command list: 8-bit bus/2 lines, display on, clear, entry mode
   localparam int         INIT_LEN = 4;
   localparam logic [7:0] INIT_CMDS [INIT_LEN] = '{8'h38, 8'h0C, 8'h01, 8'h06};

   // Field positions inside the LSU LCD register word
   localparam int BIT_POWER    = 31;
   localparam int BIT_REQ      = 10;
   localparam int BIT_RS       = 9;
   localparam int BIT_RW       = 8;
   localparam int BIT_BYTE_MSB = 7;

   // Clear display (0x01) and return home (0x02/0x03) need the long execution wait
   function automatic logic is_long_cmd(input logic rs, input logic [7:0] b);
      return !rs && (b[7:2] == 6'd0) && (b != 8'd0);
   endfunction

endpackage

// File: rtl/lcd_timer.sv
// rtl/lcd_timer.sv - loadable down-counter with a one-cycle done pulse on its last count
module lcd_timer #(
   parameter int             W         = 20,
   parameter logic [W-1:0]   RESET_VAL = '0
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          load,
   input  logic [W-1:0]  load_val,
   output logic          done
);

   logic [W-1:0] count_q;
   logic [W-1:0] count_d;

   // A load of N makes done fire in the Nth cycle after the load; the counter parks at zero
   always_comb begin
      count_d = count_q;
      if (load) begin
         count_d = load_val;
      end else if (count_q != '0) begin
         count_d = count_q - W'(1);
      end
   end

   // Count register; reset value lets the power-up wait start without an explicit load
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_q <= RESET_VAL;
      end else begin
         count_q <= count_d;
      end
   end

   assign done = (count_q == W'(1));

endmodule

// File: rtl/lcd_ctrl.sv
// rtl/lcd_ctrl.sv - HD44780 bus sequencer: power-up init, request capture, one-deep pending slot
module lcd_ctrl
   import lcd_pkg::*;
#(
   parameter int SETUP_CYC = 4,
   parameter int PULSE_CYC = 12,
   parameter int HOLD_CYC  = 4,
   parameter int EXEC_CYC  = 2000,
   parameter int CLEAR_CYC = 82000,
   parameter int PWRUP_CYC = 750000
) (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic [31:0] i_io_lcd,
   output logic [7:0]  o_lcd_data,
   output logic        o_lcd_rs,
   output logic        o_lcd_rw,
   output logic        o_lcd_en,
   output logic        o_lcd_on,
   output logic        o_lcd_busy,
   output logic        o_lcd_ovf
);

   localparam int MAX_A   = (PWRUP_CYC > CLEAR_CYC) ? PWRUP_CYC : CLEAR_CYC;
   localparam int MAX_B   = (EXEC_CYC > PULSE_CYC) ? EXEC_CYC : PULSE_CYC;
   localparam int MAX_CYC = (MAX_A > MAX_B) ? MAX_A : MAX_B;
   localparam int CNT_W   = $clog2(MAX_CYC + 1);

   lcd_state_e        state_q, state_d;
   logic [2:0]        idx_q, idx_d;
   logic              req_prev_q;
   logic              slot_full_q, slot_full_d;
   logic [7:0]        slot_data_q, slot_data_d;
   logic              slot_rs_q, slot_rs_d;
   logic              ovf_q, ovf_d;
   logic [7:0]        data_q, data_d;
   logic              rs_q, rs_d;
   logic              en_q, en_d;
   logic              on_q;

   logic              cap;
   logic              cap_used;
   logic              slot_take;
   logic              tmr_load;
   logic [CNT_W-1:0]  tmr_val;
   logic              tmr_done;
   logic              unused_bits;

   // Only the power, request, RS and byte fields matter; RW is write-only here
   assign unused_bits = ^{i_io_lcd[30:11], i_io_lcd[BIT_RW]};

   assign cap = i_io_lcd[BIT_REQ] & ~req_prev_q;

   lcd_timer #(
      .W         (CNT_W),
      .RESET_VAL (CNT_W'(PWRUP_CYC))
   ) u_timer (
      .clk      (i_clk),
      .rst      (i_reset),
      .load     (tmr_load),
      .load_val (tmr_val),
      .done     (tmr_done)
   );

   // Next-state, transfer launch and pending-slot bookkeeping
   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      data_d      = data_q;
      rs_d        = rs_q;
      slot_full_d = slot_full_q;
      slot_data_d = slot_data_q;
      slot_rs_d   = slot_rs_q;
      ovf_d       = ovf_q;
      tmr_load    = 1'b0;
      tmr_val     = '0;
      cap_used    = 1'b0;
      slot_take   = 1'b0;

      case (state_q)
         ST_PWRUP: begin
            if (tmr_done) begin
               state_d = ST_INIT;
            end
         end
         ST_INIT: begin
            data_d   = INIT_CMDS[idx_q[1:0]];
            rs_d     = 1'b0;
            idx_d    = idx_q + 3'd1;
            state_d  = ST_SETUP;
            tmr_load = 1'b1;
            tmr_val  = CNT_W'(SETUP_CYC);
         end
         ST_SETUP: begin
            if (tmr_done) begin
               state_d  = ST_PULSE;
               tmr_load = 1'b1;
               tmr_val  = CNT_W'(PULSE_CYC);
            end
         end
         ST_PULSE: begin
            if (tmr_done) begin
               state_d  = ST_HOLD;
               tmr_load = 1'b1;
               tmr_val  = CNT_W'(HOLD_CYC);
            end
         end
         ST_HOLD: begin
            if (tmr_done) begin
               state_d  = ST_WAIT;
               tmr_load = 1'b1;
               tmr_val  = is_long_cmd(rs_q, data_q) ? CNT_W'(CLEAR_CYC) : CNT_W'(EXEC_CYC);
            end
         end
         ST_WAIT: begin
            if (tmr_done) begin
               if (idx_q != 3'(INIT_LEN)) begin
                  state_d = ST_INIT;
               end else if (slot_full_q) begin
                  // Pending request goes out with no idle cycle in between
                  data_d    = slot_data_q;
                  rs_d      = slot_rs_q;
                  slot_take = 1'b1;
                  state_d   = ST_SETUP;
                  tmr_load  = 1'b1;
                  tmr_val   = CNT_W'(SETUP_CYC);
               end else if (cap) begin
                  data_d   = i_io_lcd[BIT_BYTE_MSB:0];
                  rs_d     = i_io_lcd[BIT_RS];
                  cap_used = 1'b1;
                  state_d  = ST_SETUP;
                  tmr_load = 1'b1;
                  tmr_val  = CNT_W'(SETUP_CYC);
               end else begin
                  state_d = ST_IDLE;
               end
            end
         end
         ST_IDLE: begin
            if (cap) begin
               data_d   = i_io_lcd[BIT_BYTE_MSB:0];
               rs_d     = i_io_lcd[BIT_RS];
               cap_used = 1'b1;
               state_d  = ST_SETUP;
               tmr_load = 1'b1;
               tmr_val  = CNT_W'(SETUP_CYC);
            end
         end
         default: begin
            state_d = ST_PWRUP;
         end
      endcase

      // A slot emptied this cycle can be refilled by a simultaneous capture
      if (slot_take) begin
         slot_full_d = 1'b0;
      end
      if (cap && !cap_used) begin
         if (!slot_full_d) begin
            slot_full_d = 1'b1;
            slot_data_d = i_io_lcd[BIT_BYTE_MSB:0];
            slot_rs_d   = i_io_lcd[BIT_RS];
         end else begin
            ovf_d = 1'b1;
         end
      end

      en_d = (state_d == ST_PULSE);
   end

   // State, slot and bus output registers; reset drops EN at once and restarts power-up
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         state_q     <= ST_PWRUP;
         idx_q       <= 3'd0;
         req_prev_q  <= 1'b0;
         slot_full_q <= 1'b0;
         slot_data_q <= 8'd0;
         slot_rs_q   <= 1'b0;
         ovf_q       <= 1'b0;
         data_q      <= 8'd0;
         rs_q        <= 1'b0;
         en_q        <= 1'b0;
         on_q        <= 1'b0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         req_prev_q  <= i_io_lcd[BIT_REQ];
         slot_full_q <= slot_full_d;
         slot_data_q <= slot_data_d;
         slot_rs_q   <= slot_rs_d;
         ovf_q       <= ovf_d;
         data_q      <= data_d;
         rs_q        <= rs_d;
         en_q        <= en_d;
         on_q        <= i_io_lcd[BIT_POWER];
      end
   end

   assign o_lcd_data = data_q;
   assign o_lcd_rs   = rs_q;
   assign o_lcd_rw   = 1'b0;
   assign o_lcd_en   = en_q;
   assign o_lcd_on   = on_q;
   assign o_lcd_busy = (state_q != ST_IDLE) || slot_full_q;
   assign o_lcd_ovf  = ovf_q;

endmodule

// File: tb/tb_lcd_ctrl.sv
// tb/tb_lcd_ctrl.sv - directed self-checking bench for lcd_ctrl with shortened timing
module tb_lcd_ctrl;

   localparam int SETUP = 4;
   localparam int PULSE = 12;
   localparam int HOLD  = 4;
   localparam int EXEC  = 10;
   localparam int CLEAR = 40;
   localparam int PWRUP = 20;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] io;
   logic [7:0]  o_lcd_data;
   logic        o_lcd_rs, o_lcd_rw, o_lcd_en, o_lcd_on, o_lcd_busy, o_lcd_ovf;

   int n_tests = 0;
   int n_fail  = 0;

   lcd_ctrl #(
      .SETUP_CYC (SETUP), .PULSE_CYC (PULSE), .HOLD_CYC (HOLD),
      .EXEC_CYC  (EXEC),  .CLEAR_CYC (CLEAR), .PWRUP_CYC (PWRUP)
   ) dut (
      .i_clk      (clk),
      .i_reset    (rst),
      .i_io_lcd   (io),
      .o_lcd_data (o_lcd_data),
      .o_lcd_rs   (o_lcd_rs),
      .o_lcd_rw   (o_lcd_rw),
      .o_lcd_en   (o_lcd_en),
      .o_lcd_on   (o_lcd_on),
      .o_lcd_busy (o_lcd_busy),
      .o_lcd_ovf  (o_lcd_ovf)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Bus monitor sampling 1ns after each rising edge
   int         r_cyc[$];
   logic [7:0] r_data[$];
   logic       r_rs[$];
   int         w_len[$];
   int         last_rise = 0;
   int         busy_cnt = 0;
   logic       en_prev = 1'b0;
   always begin
      @(posedge clk);
      #1;
      if (o_lcd_busy) busy_cnt++;
      if (o_lcd_en && !en_prev) begin
         r_cyc.push_back(cyc);
         r_data.push_back(o_lcd_data);
         r_rs.push_back(o_lcd_rs);
         last_rise = cyc;
      end
      if (!o_lcd_en && en_prev) w_len.push_back(cyc - last_rise);
      en_prev = o_lcd_en;
   end

   task automatic clear_log();
      r_cyc.delete(); r_data.delete(); r_rs.delete(); w_len.delete();
      busy_cnt = 0;
   endtask

   // Present v with the request bit set so edge number e samples the rising edge
   task automatic drive_at(input int e, input logic [31:0] v);
      while (cyc < e - 1) @(negedge clk);
      io = v | 32'h0000_0400;
      @(negedge clk);
      io = v & ~32'h0000_0400;
   endtask

   task automatic wait_idle(input int bound, output bit to);
      int n = 0;
      @(negedge clk);
      while (o_lcd_busy && n < bound) begin
         @(negedge clk);
         n++;
      end
      to = o_lcd_busy;
   endtask

   task automatic test_reset();
      n_tests++; if (o_lcd_en !== 1'b0)   begin n_fail++; $display("FAIL rst_en: got %b want 0", o_lcd_en); end
      n_tests++; if (o_lcd_data !== 8'h0) begin n_fail++; $display("FAIL rst_data: got %h want 00", o_lcd_data); end
      n_tests++; if (o_lcd_rs !== 1'b0)   begin n_fail++; $display("FAIL rst_rs: got %b want 0", o_lcd_rs); end
      n_tests++; if (o_lcd_rw !== 1'b0)   begin n_fail++; $display("FAIL rst_rw: got %b want 0", o_lcd_rw); end
      n_tests++; if (o_lcd_busy !== 1'b1) begin n_fail++; $display("FAIL rst_busy: got %b want 1", o_lcd_busy); end
      n_tests++; if (o_lcd_ovf !== 1'b0)  begin n_fail++; $display("FAIL rst_ovf: got %b want 0", o_lcd_ovf); end
      n_tests++; if (o_lcd_on !== 1'b0)   begin n_fail++; $display("FAIL rst_on: got %b want 0", o_lcd_on); end
   endtask

   // Releases reset and checks the four init transfers and their spacing
   task automatic test_init(input string tag);
      int         rel;
      bit         to;
      int         offs [4] = '{25, 56, 87, 148};
      logic [7:0] cmds [4] = '{8'h38, 8'h0C, 8'h01, 8'h06};
      clear_log();
      rst = 1'b0;
      rel = cyc;
      wait_idle(400, to);
      n_tests++; if (to !== 1'b0) begin n_fail++; $display("FAIL %s_timeout: busy still %b", tag, o_lcd_busy); end
      n_tests++; if (cyc - rel !== 174) begin n_fail++; $display("FAIL %s_idle_time: got %0d want 174", tag, cyc - rel); end
      repeat (50) @(negedge clk);
      n_tests++; if (r_cyc.size() !== 4) begin n_fail++; $display("FAIL %s_pulses: got %0d want 4", tag, r_cyc.size()); end
      for (int i = 0; i < 4; i++) begin
         int   gc = (i < r_cyc.size()) ? r_cyc[i] - rel : -1;
         logic [7:0] gd = (i < r_data.size()) ? r_data[i] : 8'hxx;
         logic gr = (i < r_rs.size()) ? r_rs[i] : 1'bx;
         int   gw = (i < w_len.size()) ? w_len[i] : -1;
         n_tests++;
         if (gc !== offs[i] || gd !== cmds[i] || gr !== 1'b0 || gw !== PULSE) begin
            n_fail++;
            $display("FAIL %s_cmd%0d: at %0d data %h rs %b width %0d, want %0d %h 0 %0d",
                     tag, i, gc, gd, gr, gw, offs[i], cmds[i], PULSE);
         end
      end
      n_tests++; if (o_lcd_on !== 1'b1) begin n_fail++; $display("FAIL %s_on: got %b want 1", tag, o_lcd_on); end
      n_tests++; if (o_lcd_data !== 8'h06) begin n_fail++; $display("FAIL %s_data_hold: got %h want 06", tag, o_lcd_data); end
   endtask

   task automatic test_single();
      int n;
      bit to;
      clear_log();
      n = cyc + 1;
      drive_at(n, 32'h8000_0641);
      wait_idle(200, to);
      n_tests++; if (to !== 1'b0) begin n_fail++; $display("FAIL single_timeout: busy %b", o_lcd_busy); end
      n_tests++; if (r_cyc.size() !== 1) begin n_fail++; $display("FAIL single_pulses: got %0d want 1", r_cyc.size()); end
      if (r_cyc.size() > 0) begin
         n_tests++; if (r_cyc[0] - n !== SETUP) begin n_fail++; $display("FAIL single_setup: got %0d want %0d", r_cyc[0] - n, SETUP); end
         n_tests++; if (r_data[0] !== 8'h41 || r_rs[0] !== 1'b1) begin n_fail++; $display("FAIL single_bus: got %h/%b want 41/1", r_data[0], r_rs[0]); end
      end
      if (w_len.size() > 0) begin
         n_tests++; if (w_len[0] !== PULSE) begin n_fail++; $display("FAIL single_width: got %0d want %0d", w_len[0], PULSE); end
      end
      n_tests++; if (busy_cnt !== 30) begin n_fail++; $display("FAIL single_busy: got %0d want 30", busy_cnt); end
      n_tests++; if (o_lcd_data !== 8'h41 || o_lcd_rs !== 1'b1) begin n_fail++; $display("FAIL single_hold: got %h/%b want 41/1", o_lcd_data, o_lcd_rs); end
      n_tests++; if (o_lcd_rw !== 1'b0) begin n_fail++; $display("FAIL single_rw: got %b want 0", o_lcd_rw); end
   endtask

   // Multi-request scenario: k request edges at given offsets, expected transfers and drop
   task automatic run_multi(input string tag, input int k, input int dly [3], input logic [31:0] v [3],
                            input int nx, input int offs [3], input int busy_exp, input logic ovf_exp);
      int n;
      bit to;
      clear_log();
      n = cyc + 1;
      for (int i = 0; i < k; i++) drive_at(n + dly[i], v[i]);
      wait_idle(300, to);
      repeat (50) @(negedge clk);
      n_tests++; if (to !== 1'b0) begin n_fail++; $display("FAIL %s_timeout: busy %b", tag, o_lcd_busy); end
      n_tests++; if (r_cyc.size() !== nx) begin n_fail++; $display("FAIL %s_pulses: got %0d want %0d", tag, r_cyc.size(), nx); end
      for (int i = 0; i < nx; i++) begin
         int   gc = (i < r_cyc.size()) ? r_cyc[i] - n : -1;
         logic [7:0] gd = (i < r_data.size()) ? r_data[i] : 8'hxx;
         logic [31:0] vi = v[i];
         n_tests++;
         if (gc !== offs[i] || gd !== vi[7:0]) begin
            n_fail++;
            $display("FAIL %s_xfer%0d: at %0d data %h, want %0d %h", tag, i, gc, gd, offs[i], vi[7:0]);
         end
      end
      n_tests++; if (busy_cnt !== busy_exp) begin n_fail++; $display("FAIL %s_busy: got %0d want %0d", tag, busy_cnt, busy_exp); end
      n_tests++; if (o_lcd_ovf !== ovf_exp) begin n_fail++; $display("FAIL %s_ovf: got %b want %b", tag, o_lcd_ovf, ovf_exp); end
   endtask

   task automatic test_back_to_back();
      run_multi("b2b", 2, '{0, 3, 0}, '{32'h8000_0641, 32'h8000_0642, 32'h0}, 2, '{4, 34, 0}, 60, 1'b0);
      run_multi("wend_empty", 2, '{0, 30, 0}, '{32'h8000_0655, 32'h8000_0656, 32'h0}, 2, '{4, 34, 0}, 60, 1'b0);
      run_multi("wend_full", 3, '{0, 2, 30}, '{32'h8000_0661, 32'h8000_0662, 32'h8000_0663}, 3, '{4, 34, 64}, 90, 1'b0);
   endtask

   task automatic test_exec_select();
      logic [31:0] vs [5] = '{32'h8000_0401, 32'h8000_0480, 32'h8000_0403, 32'h8000_0400, 32'h8000_0602};
      int          bs [5] = '{60, 30, 60, 30, 30};
      for (int i = 0; i < 5; i++) begin
         int n;
         bit to;
         logic [31:0] vi = vs[i];
         clear_log();
         n = cyc + 1;
         drive_at(n, vi);
         wait_idle(200, to);
         n_tests++;
         if (to !== 1'b0 || busy_cnt !== bs[i] || r_data.size() !== 1 || o_lcd_data !== vi[7:0] || o_lcd_rs !== vi[9]) begin
            n_fail++;
            $display("FAIL exec_%h: busy %0d pulses %0d data %h rs %b, want %0d 1 %h %b",
                     vi[10:0], busy_cnt, r_data.size(), o_lcd_data, o_lcd_rs, bs[i], vi[7:0], vi[9]);
         end
      end
   endtask

   task automatic test_overflow();
      run_multi("drop", 3, '{0, 2, 4}, '{32'h8000_0671, 32'h8000_0672, 32'h8000_0673}, 2, '{4, 34, 0}, 60, 1'b1);
      run_multi("ovf_sticky", 1, '{0, 0, 0}, '{32'h8000_0674, 32'h0, 32'h0}, 1, '{4, 0, 0}, 30, 1'b1);
   endtask

   task automatic test_reset_mid();
      int n;
      n = cyc + 1;
      drive_at(n, 32'h8000_0681);
      drive_at(n + 2, 32'h8000_0682);
      n = 0;
      while (!o_lcd_en && n < 50) begin
         @(negedge clk);
         n++;
      end
      n_tests++; if (o_lcd_en !== 1'b1) begin n_fail++; $display("FAIL mid_en_seen: got %b want 1", o_lcd_en); end
      #2 rst = 1'b1;
      #1;
      n_tests++; if (o_lcd_en !== 1'b0) begin n_fail++; $display("FAIL mid_en_drop: got %b want 0", o_lcd_en); end
      n_tests++; if (o_lcd_busy !== 1'b1 || o_lcd_ovf !== 1'b0) begin n_fail++; $display("FAIL mid_status: busy %b ovf %b want 1 0", o_lcd_busy, o_lcd_ovf); end
      n_tests++; if (o_lcd_data !== 8'h0 || o_lcd_rs !== 1'b0 || o_lcd_on !== 1'b0) begin n_fail++; $display("FAIL mid_bus: data %h rs %b on %b want 00 0 0", o_lcd_data, o_lcd_rs, o_lcd_on); end
      repeat (3) @(negedge clk);
      test_init("reinit");
   endtask

   initial begin
      rst = 1'b1;
      io  = 32'h8000_0000;
      repeat (3) @(negedge clk);
      test_reset();
      test_init("init");
      test_single();
      test_back_to_back();
      test_exec_select();
      test_overflow();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
